// File: rtl/seq_detect_sched.sv
// Programmable serial pattern detector: bytes in over valid/ready, shifted MSB-first
// through a compare window; counts matches and raises a sticky threshold interrupt.
module seq_detect_sched #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned LEN_W = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             seq_seen,
  output logic [CNT_W-1:0] match_count,
  output logic             irq,
  input  logic             irq_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [PAT_W-1:0]   window_q, window_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic               seq_seen_q, seq_seen_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               irq_q, irq_d;

  logic               accept;
  logic [PAT_W-1:0]   win_next;
  logic [PAT_W-1:0]   mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   len_clamped;
  logic               match;

  // Ready combines the idle-armed case with the last bit of a byte so streams run gap-free.
  assign in_ready = ((state_q == ST_ARMED) |
                     ((state_q == ST_SHIFT) & (bit_cnt_q == 3'd0))) & ~stop;
  assign busy        = (state_q != ST_IDLE);
  assign seq_seen    = seq_seen_q;
  assign match_count = count_q;
  assign irq         = irq_q;
  assign accept      = in_valid & in_ready;

  assign len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

  // Window compare for the bit that enters on the next shift edge.
  always_comb begin
    win_next = {window_q[PAT_W-2:0], byte_q[7]};
    fill_inc = (fill_q < len_q) ? LEN_W'(fill_q + 1'b1) : fill_q;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    match = (len_q != '0) && (fill_inc >= len_q) &&
            ((win_next & mask) == (pat_q & mask));
  end

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    bit_cnt_d  = bit_cnt_q;
    window_d   = window_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    len_d      = len_q;
    ovl_d      = ovl_q;
    thresh_d   = thresh_q;
    seq_seen_d = 1'b0;
    count_d    = count_q;
    irq_d      = irq_q & ~irq_clr;

    if (stop) begin
      state_d  = ST_IDLE;
      window_d = '0;
      fill_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_ARMED;
            pat_d    = cfg_pattern;
            len_d    = len_clamped;
            ovl_d    = cfg_overlap;
            thresh_d = cfg_thresh;
            count_d  = '0;
            window_d = '0;
            fill_d   = '0;
            irq_d    = 1'b0;
          end
        end
        ST_ARMED: begin
          if (accept) begin
            state_d   = ST_SHIFT;
            byte_d    = in_data;
            bit_cnt_d = 3'd7;
          end
        end
        ST_SHIFT: begin
          byte_d     = {byte_q[6:0], 1'b0};
          bit_cnt_d  = 3'(bit_cnt_q - 1'b1);
          window_d   = win_next;
          fill_d     = (match && !ovl_q) ? '0 : fill_inc;
          seq_seen_d = match;
          // Saturated counter neither wraps nor re-fires the interrupt.
          if (match && !(&count_q)) begin
            count_d = CNT_W'(count_q + 1'b1);
            if ((thresh_q != '0) && (CNT_W'(count_q + 1'b1) == thresh_q)) begin
              irq_d = 1'b1;
            end
          end
          if (bit_cnt_q == 3'd0) begin
            if (accept) begin
              byte_d    = in_data;
              bit_cnt_d = 3'd7;
            end else begin
              state_d = ST_ARMED;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      byte_q     <= '0;
      bit_cnt_q  <= '0;
      window_q   <= '0;
      fill_q     <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      ovl_q      <= 1'b0;
      thresh_q   <= '0;
      seq_seen_q <= 1'b0;
      count_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      bit_cnt_q  <= bit_cnt_d;
      window_q   <= window_d;
      fill_q     <= fill_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      ovl_q      <= ovl_d;
      thresh_q   <= thresh_d;
      seq_seen_q <= seq_seen_d;
      count_q    <= count_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched: hand-computed match positions, counts, irq and stop/reset.
module tb_seq_detect_sched;

  logic       clk;
  logic       reset_n;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_thresh;
  logic       start, stop, in_valid, irq_clr;
  logic [7:0] in_data;
  logic       in_ready, busy, seq_seen, irq;
  logic [7:0] match_count;

  int n_checks = 0;
  int n_errs   = 0;

  seq_detect_sched dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_thresh  (cfg_thresh),
    .start       (start),
    .stop        (stop),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .seq_seen    (seq_seen),
    .match_count (match_count),
    .irq         (irq),
    .irq_clr     (irq_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] pat, input logic [2:0] len,
                          input logic ovl, input logic [7:0] thr);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_thresh  = thr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic run_bits(input int n, output logic [15:0] seen);
    seen = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      seen[i] = seq_seen;
    end
  endtask

  // One byte: wait for ready (bounded), handshake at E0, then shift edges E1..E8.
  task automatic send_byte(input logic [7:0] b, output logic [7:0] seen);
    logic [15:0] s;
    int t;
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (t == 20) check("ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    run_bits(8, s);
    seen = s[7:0];
  endtask

  initial begin
    logic [7:0]  seen8;
    logic [15:0] seen16, rv;

    reset_n = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_thresh = '0;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = '0; irq_clr = 1'b0;
    #12;
    check("rst_outputs", {27'd0, in_ready, busy, seq_seen, irq, |match_count}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: overlap, 0xB6 -> matches at E4 and E7
    do_start(4'b1011, 3'd4, 1'b1, 8'd0);
    check("t1_busy", 32'(busy), 32'd1);
    send_byte(8'hB6, seen8);
    check("t1_seen", 32'(seen8), 32'h48);
    check("t1_count", 32'(match_count), 32'd2);
    check("t1_ready_armed", 32'(in_ready), 32'd1);

    // 2: no overlap -> only E4
    do_stop();
    do_start(4'b1011, 3'd4, 1'b0, 8'd0);
    send_byte(8'hB6, seen8);
    check("t2_seen", 32'(seen8), 32'h08);
    check("t2_count", 32'(match_count), 32'd1);

    // 3: back-to-back 0x0B,0x00, ready only before E8 and E16
    do_stop();
    do_start(4'b1011, 3'd4, 1'b1, 8'd0);
    in_valid = 1'b1;
    in_data  = 8'h0B;
    check("t3_ready_e0", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'h00;
    rv = '0;
    seen16 = '0;
    for (int k = 0; k < 16; k++) begin
      rv[k] = in_ready;
      tick();
      seen16[k] = seq_seen;
      if (k == 7) in_valid = 1'b0;
    end
    check("t3_ready_vec", 32'(rv), 32'h8080);
    check("t3_seen", 32'(seen16), 32'h0080);
    check("t3_count", 32'(match_count), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);

    // 4: thresh=3 with 0xBB x2; irq_clr coincides with 4th match
    do_stop();
    do_start(4'b1011, 3'd4, 1'b1, 8'd3);
    in_valid = 1'b1;
    in_data  = 8'hBB;
    tick();
    seen16 = '0;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      seen16[k] = seq_seen;
      if (k == 7) in_valid = 1'b0;
      if (k == 10) check("t4_irq_before", 32'(irq), 32'd0);
      if (k == 11) begin
        check("t4_irq_set", 32'(irq), 32'd1);
        check("t4_count3", 32'(match_count), 32'd3);
      end
    end
    check("t4_seen", 32'(seen16), 32'h8888);
    check("t4_irq_cleared", 32'(irq), 32'd0);
    check("t4_count4", 32'(match_count), 32'd4);

    // 5: len 0 never matches, len 7 clamps to 4
    do_stop();
    do_start(4'b1011, 3'd0, 1'b1, 8'd0);
    send_byte(8'hB6, seen8);
    check("t5_len0_count", 32'(match_count), 32'd0);
    check("t5_len0_seen", 32'(seen8), 32'd0);
    do_stop();
    do_start(4'b1011, 3'd7, 1'b1, 8'd0);
    send_byte(8'hB6, seen8);
    check("t5_len7_count", 32'(match_count), 32'd2);
    check("t5_len7_seen", 32'(seen8), 32'h48);

    // 6a: async reset at E3 of a byte clears everything immediately
    do_stop();
    do_start(4'b1011, 3'd4, 1'b1, 8'd1);
    send_byte(8'hB6, seen8);
    check("t6_irq_pre", 32'(irq), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hB6;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_outputs", {23'd0, in_ready, busy, seq_seen, irq, match_count[3:0]}, 32'd0);
    #3 reset_n = 1'b1;
    in_valid = 1'b1;
    tick();
    check("t6_rst_idle", {30'd0, in_ready, busy}, 32'd0);
    in_valid = 1'b0;

    // 6b: stop at E3 drops the rest of the byte but keeps the count
    do_start(4'b1011, 3'd4, 1'b1, 8'd0);
    send_byte(8'hB6, seen8);
    in_valid = 1'b1;
    in_data  = 8'hB6;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    do_stop();
    check("t6_stop_idle", {30'd0, in_ready, busy}, 32'd0);
    run_bits(3, seen16);
    check("t6_stop_noseen", 32'(seen16), 32'd0);
    check("t6_stop_count", 32'(match_count), 32'd2);

    // stop wins over start; a later start clears the count
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("stop_beats_start", 32'(busy), 32'd0);
    do_start(4'b1011, 3'd4, 1'b1, 8'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_count", 32'(match_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
